sysray_feeder: RTL and testbench

Upstream input stage for the systolic array. Accepts one N-byte activation row per valid/ready handshake and emits it diagonally skewed: lane i is delayed i cycles relative to lane 0, with a per-lane valid bit. Its outputs drive the array's `sysdata_i` / `in_valid_input` ports directly. A start/length command frames each tile; after the last row the feeder drains the skew pipeline and pulses `done_o`.

---
 rtl/sysray_feeder.sv | 125 ++++++++++++
 tb/tb_sysray_feeder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysray_feeder.sv
// rtl/sysray_feeder.sv - row-to-diagonal skew feeder driving the systolic array inputs
// Optional FEEDER_ZERO_GATE_EN: lane data forced to 0 on every invalid slot.
module sysray_feeder #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic                  row_valid_i,
  output logic                  row_ready_o,
  input  logic [N*DATA_W-1:0]   row_data_i,
  output logic [DATA_W-1:0]     sysdata_o [N],
  output logic [N-1:0]          valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  // Drain counts 0..N-2; the extra edge is the one that accepted the last row.
  localparam int DCW = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((N > 1) ? N - 2 : 0);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] acc_cnt;
  logic [DCW-1:0]   drain_cnt;
  logic             accept;

  assign row_ready_o = (state == STREAM) && (acc_cnt < len_q);
  assign accept      = row_valid_i && row_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      acc_cnt   <= '0;
      drain_cnt <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            len_q   <= len_i;
            acc_cnt <= '0;
            if (len_i == '0) begin
              done_o <= 1'b1;
            end else begin
              state  <= STREAM;
              busy_o <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            acc_cnt <= acc_cnt + 1'b1;
            if (acc_cnt == len_q - 1'b1) begin
              if (N == 1) begin
                state  <= IDLE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end else begin
                state     <= DRAIN;
                drain_cnt <= '0;
              end
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane i is an (i+1)-deep {valid, data} shift register fed by the accept strobe.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic              st_v [i+1];
    logic [DATA_W-1:0] st_d [i+1];
    logic              in_v [i+1];
    logic [DATA_W-1:0] in_d [i+1];

    always_comb begin
      in_v[0] = accept;
      in_d[0] = row_data_i[i*DATA_W +: DATA_W];
      for (int j = 1; j <= i; j++) begin
        in_v[j] = st_v[j-1];
        in_d[j] = st_d[j-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) begin
          st_v[j] <= 1'b0;
          st_d[j] <= '0;
        end
      end else begin
        for (int j = 0; j <= i; j++) begin
          st_v[j] <= in_v[j];
          if (in_v[j]) st_d[j] <= in_d[j];
`ifdef FEEDER_ZERO_GATE_EN
          else st_d[j] <= '0;
`endif
        end
      end
    end

    assign valid_o[i]   = st_v[i];
    assign sysdata_o[i] = st_d[i];
  end

endmodule

// File: tb/tb_sysray_feeder.sv
// tb/tb_sysray_feeder.sv - self-checking bench for sysray_feeder (N=4 and N=1 instances)
module tb_sysray_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start4 = 1'b0, rv4 = 1'b0, rr4, busy4, done4;
  logic [15:0] len4 = '0;
  logic [31:0] rd4 = '0;
  logic [7:0]  sd4 [4];
  logic [3:0]  v4;

  logic        start1 = 1'b0, rv1 = 1'b0, rr1, busy1, done1;
  logic [15:0] len1 = '0;
  logic [7:0]  rd1 = '0;
  logic [7:0]  sd1 [1];
  logic [0:0]  v1;

  sysray_feeder #(.N(4), .DATA_W(8), .LEN_W(16)) dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .len_i(len4), .row_valid_i(rv4),
    .row_ready_o(rr4), .row_data_i(rd4), .sysdata_o(sd4), .valid_o(v4),
    .busy_o(busy4), .done_o(done4));

  sysray_feeder #(.N(1), .DATA_W(8), .LEN_W(16)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .len_i(len1), .row_valid_i(rv1),
    .row_ready_o(rr1), .row_data_i(rd1), .sysdata_o(sd1), .valid_o(v1),
    .busy_o(busy1), .done_o(done1));

  int checks = 0;
  int failures = 0;
`ifdef FEEDER_ZERO_GATE_EN
  bit gate = 1'b1;
`else
  bit gate = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: per-edge accept history; lane i after edge e shows the row accepted at edge e-i.
  int          nl [2] = '{4, 1};
  int          ec [2];
  bit          strm [2];
  int          mlen [2];
  int          mcnt [2];
  int          done_e [2];
  bit          hv [2][4096];
  logic [31:0] hd [2][4096];
  logic [7:0]  hold [2][4];

  function automatic bit m_ready(input int u);
    return strm[u] && (mcnt[u] < mlen[u]);
  endfunction

  task automatic m_clear(input int u);
    ec[u] = 0; strm[u] = 0; mlen[u] = 0; mcnt[u] = 0; done_e[u] = -100;
    for (int i = 0; i < 4; i++) hold[u][i] = 8'h00;
  endtask

  task automatic m_edge(input int u, input bit st, input int ln, input bit v, input logic [31:0] d);
    int e;
    bit idle, acc;
    e = ec[u];
    idle = !(strm[u] || ((e - 1) < done_e[u]));
    acc = v && m_ready(u);
    if (e < 4096) begin
      hv[u][e] = acc;
      hd[u][e] = d;
    end
    if (acc) begin
      mcnt[u]++;
      if (mcnt[u] == mlen[u]) begin
        strm[u] = 0;
        done_e[u] = e + nl[u] - 1;
      end
    end else if (idle && st) begin
      if (ln == 0) done_e[u] = e;
      else begin
        strm[u] = 1; mlen[u] = ln; mcnt[u] = 0;
      end
    end
    ec[u]++;
  endtask

  task automatic cmp(input int u);
    int cur, idx;
    bit ev;
    logic [7:0] ed, act_d;
    cur = ec[u] - 1;
    chk($sformatf("n%0d_ready", nl[u]), 32'(u == 0 ? rr4 : rr1), 32'(m_ready(u)));
    chk($sformatf("n%0d_busy", nl[u]), 32'(u == 0 ? busy4 : busy1),
        32'(strm[u] || (cur < done_e[u])));
    chk($sformatf("n%0d_done", nl[u]), 32'(u == 0 ? done4 : done1),
        32'(cur >= 0 && cur == done_e[u]));
    for (int i = 0; i < nl[u]; i++) begin
      idx = cur - i;
      ev = (idx >= 0) && (idx < 4096) && hv[u][idx];
      if (ev) hold[u][i] = hd[u][idx][i*8 +: 8];
      ed = gate ? (ev ? hold[u][i] : 8'h00) : hold[u][i];
      act_d = (u == 0) ? sd4[i] : sd1[0];
      chk($sformatf("n%0d_lane%0d_valid", nl[u], i), 32'(u == 0 ? v4[i] : v1[0]), 32'(ev));
      chk($sformatf("n%0d_lane%0d_data", nl[u], i), 32'(act_d), 32'(ed));
    end
  endtask

  initial begin
    m_clear(0);
    m_clear(1);
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_clear(0);
        m_clear(1);
      end else begin
        m_edge(0, start4, int'(len4), rv4, rd4);
        m_edge(1, start1, int'(len1), rv1, {24'h0, rd1});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cmp(0);
      cmp(1);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int acc_n, done_n;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rr4), 32'h0);
    chk("rst_valid", 32'(v4), 32'h0);
    chk("rst_busy", 32'(busy4), 32'h0);
    rst = 1'b0;
    tick;

    // continuous tile, len=3
    start4 = 1; len4 = 3; tick; start4 = 0;
    chk("t1_ready_up", 32'(rr4), 32'h1);
    rv4 = 1; rd4 = 32'h04030201; tick;
    chk("t1_l0_r0", 32'(sd4[0]), 32'h01);
    chk("t1_v_e1", 32'(v4), 32'h1);
    rd4 = 32'h08070605; tick;
    chk("t1_l0_r1", 32'(sd4[0]), 32'h05);
    chk("t1_l1_r0", 32'(sd4[1]), 32'h02);
    chk("t1_v_e2", 32'(v4), 32'h3);
    rd4 = 32'h0C0B0A09; tick;
    chk("t1_l0_r2", 32'(sd4[0]), 32'h09);
    chk("t1_ready_low", 32'(rr4), 32'h0);
    rv4 = 0; rd4 = 32'h0; tick;
    chk("t1_l3_r0", 32'(sd4[3]), 32'h04);
    chk("t1_v_e4", 32'(v4), 32'hE);
    tick;
    chk("t1_l3_r1", 32'(sd4[3]), 32'h08);
    tick;
    chk("t1_l3_r2", 32'(sd4[3]), 32'h0C);
    chk("t1_done", 32'(done4), 32'h1);
    chk("t1_busy_low", 32'(busy4), 32'h0);
    chk("t1_v_e6", 32'(v4), 32'h8);
    tick;
    chk("t1_done_pulse", 32'(done4), 32'h0);
    tick;

    // same tile with a 2-cycle gap after row 0
    start4 = 1; len4 = 3; tick; start4 = 0;
    rv4 = 1; rd4 = 32'h04030201; tick;
    rv4 = 0; rd4 = 32'hDEADBEEF; tick; tick;
    chk("t2_v_gap", 32'(v4), 32'h4);
    chk("t2_l0_gap_data", 32'(sd4[0]), gate ? 32'h00 : 32'h01);
    rv4 = 1; rd4 = 32'h08070605; tick;
    rd4 = 32'h0C0B0A09; tick;
    rv4 = 0; rd4 = 32'h0;
    repeat (6) tick;

    // len=0
    start4 = 1; len4 = 0; tick; start4 = 0;
    chk("t3_done", 32'(done4), 32'h1);
    chk("t3_ready", 32'(rr4), 32'h0);
    chk("t3_busy", 32'(busy4), 32'h0);
    tick;
    chk("t3_done_pulse", 32'(done4), 32'h0);
    tick;

    // start during STREAM is ignored
    start4 = 1; len4 = 3; tick; start4 = 0;
    rv4 = 1; rd4 = 32'h11223344;
    acc_n = 0; done_n = 0;
    for (int k = 0; k < 14; k++) begin
      if (k == 1) begin start4 = 1; len4 = 5; end
      else start4 = 0;
      if (rr4 && rv4) acc_n++;
      tick;
      if (done4) done_n++;
      rd4 = rd4 + 32'h01010101;
    end
    start4 = 0; rv4 = 0;
    chk("t4_accepts", 32'(acc_n), 32'd3);
    chk("t4_dones", 32'(done_n), 32'd1);
    tick;

    // async reset mid-DRAIN
    start4 = 1; len4 = 2; tick; start4 = 0;
    rv4 = 1; rd4 = 32'hA4A3A2A1; tick;
    rd4 = 32'hB4B3B2B1; tick;
    rv4 = 0; rd4 = 32'h0; tick;
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", 32'(v4), 32'h0);
    chk("t5_l0", 32'(sd4[0]), 32'h0);
    chk("t5_l3", 32'(sd4[3]), 32'h0);
    chk("t5_busy", 32'(busy4), 32'h0);
    chk("t5_done", 32'(done4), 32'h0);
    chk("t5_ready", 32'(rr4), 32'h0);
    tick;
    rst = 1'b0;
    done_n = 0;
    repeat (6) begin tick; if (done4) done_n++; end
    chk("t5_no_done", 32'(done_n), 32'd0);
    start4 = 1; len4 = 3; tick; start4 = 0;
    rv4 = 1; rd4 = 32'h31323334; tick;
    rd4 = 32'h41424344; tick;
    rd4 = 32'h51525354; tick;
    rv4 = 0; rd4 = 32'h0;
    done_n = 0;
    repeat (6) begin tick; if (done4) done_n++; end
    chk("t5_new_tile_done", 32'(done_n), 32'd1);

    // N=1, len=2
    start1 = 1; len1 = 2; tick; start1 = 0;
    rv1 = 1; rd1 = 8'hAA; tick;
    chk("t6_d0", 32'(sd1[0]), 32'hAA);
    chk("t6_v0", 32'(v1), 32'h1);
    chk("t6_nodone", 32'(done1), 32'h0);
    rd1 = 8'hBB; tick;
    chk("t6_d1", 32'(sd1[0]), 32'hBB);
    chk("t6_done", 32'(done1), 32'h1);
    chk("t6_busy", 32'(busy1), 32'h0);
    rv1 = 0; rd1 = 8'h0; tick;
    chk("t6_done_pulse", 32'(done1), 32'h0);
    chk("t6_v_end", 32'(v1), 32'h0);
    repeat (3) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
